// File: rtl/fetch_stage_if.sv
// Bundles the instruction-memory port and the fetch/decode-facing signals of fetch_stage.
// The slave modport is the fetch stage itself; the master side is whoever surrounds it.
interface fetch_stage_if #(
   parameter int PC_W = 16
);
   logic [PC_W-1:0] imem_addr;
   logic [15:0]     imem_rdata;
   logic            stall;
   logic            branch_taken;
   logic [PC_W-1:0] branch_target;
   logic [15:0]     COMMAND;
   logic [15:0]     BeforeCOMMAND;
   logic [15:0]     TwoBeforeCOMMAND;
   logic [PC_W-1:0] cmd_pc;
   logic            halted;

   modport slave (
      output imem_addr,
      input  imem_rdata,
      input  stall,
      input  branch_taken,
      input  branch_target,
      output COMMAND,
      output BeforeCOMMAND,
      output TwoBeforeCOMMAND,
      output cmd_pc,
      output halted
   );

   modport master (
      input  imem_addr,
      output imem_rdata,
      output stall,
      output branch_taken,
      output branch_target,
      input  COMMAND,
      input  BeforeCOMMAND,
      input  TwoBeforeCOMMAND,
      input  cmd_pc,
      input  halted
   );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch with two-deep issue history for the decoder's forwarding logic.
// Handles branch redirect (two bubbles), stall with in-flight re-read, and a sticky HALT.
module fetch_stage #(
   parameter int              PC_W      = 16,
   parameter logic [PC_W-1:0] RESET_PC  = '0,
   parameter logic [15:0]     NOP_WORD  = 16'hC0F0,
   parameter logic [15:0]     HALT_WORD = 16'hC0FF
) (
   input logic          clk,
   input logic          rst_n,
   fetch_stage_if.slave bus
);

   typedef enum logic {S_RUN, S_HALT} state_t;

   state_t          r_state,  w_state_nxt;
   logic [PC_W-1:0] r_pc,     w_pc_nxt;
   logic [PC_W-1:0] r_rd_pc,  w_rd_pc_nxt;
   logic [PC_W-1:0] r_cmd_pc, w_cmd_pc_nxt;
   logic            r_fv,     w_fv_nxt;
   logic            r_halted, w_halted_nxt;
   logic [15:0]     r_cmd,    w_cmd_nxt;
   logic [15:0]     r_before, w_before_nxt;
   logic [15:0]     r_two,    w_two_nxt;
   logic [15:0]     w_load;

   // A stall re-issues the in-flight address so imem_rdata still holds that word next cycle.
   assign bus.imem_addr = (r_state == S_RUN && bus.stall && !bus.branch_taken) ? r_rd_pc : r_pc;

   assign bus.COMMAND          = r_cmd;
   assign bus.BeforeCOMMAND    = r_before;
   assign bus.TwoBeforeCOMMAND = r_two;
   assign bus.cmd_pc           = r_cmd_pc;
   assign bus.halted           = r_halted;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_RUN;
         r_pc     <= RESET_PC;
         r_rd_pc  <= RESET_PC;
         r_cmd_pc <= '0;
         r_fv     <= 1'b0;
         r_halted <= 1'b0;
         r_cmd    <= NOP_WORD;
         r_before <= NOP_WORD;
         r_two    <= NOP_WORD;
      end else begin
         r_state  <= w_state_nxt;
         r_pc     <= w_pc_nxt;
         r_rd_pc  <= w_rd_pc_nxt;
         r_cmd_pc <= w_cmd_pc_nxt;
         r_fv     <= w_fv_nxt;
         r_halted <= w_halted_nxt;
         r_cmd    <= w_cmd_nxt;
         r_before <= w_before_nxt;
         r_two    <= w_two_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_pc_nxt     = r_pc;
      w_rd_pc_nxt  = r_rd_pc;
      w_cmd_pc_nxt = r_cmd_pc;
      w_fv_nxt     = r_fv;
      w_halted_nxt = r_halted;
      w_cmd_nxt    = r_cmd;
      w_before_nxt = r_before;
      w_two_nxt    = r_two;
      w_load       = r_fv ? bus.imem_rdata : NOP_WORD;

      case (r_state)
         S_RUN: begin
            if (bus.branch_taken) begin
               // Squash the in-flight word; the refetch from the target costs one more bubble.
               w_pc_nxt     = bus.branch_target;
               w_rd_pc_nxt  = bus.branch_target;
               w_fv_nxt     = 1'b0;
               w_cmd_nxt    = NOP_WORD;
               w_before_nxt = r_cmd;
               w_two_nxt    = r_before;
               w_cmd_pc_nxt = r_rd_pc;
            end else if (!bus.stall) begin
               w_pc_nxt     = r_pc + 1'b1;
               w_rd_pc_nxt  = r_pc;
               w_fv_nxt     = 1'b1;
               w_cmd_nxt    = w_load;
               w_before_nxt = r_cmd;
               w_two_nxt    = r_before;
               w_cmd_pc_nxt = r_rd_pc;
               if (w_load == HALT_WORD) begin
                  w_state_nxt  = S_HALT;
                  w_halted_nxt = 1'b1;
               end
            end
         end
         S_HALT: begin
            w_cmd_nxt    = NOP_WORD;
            w_before_nxt = r_cmd;
            w_two_nxt    = r_before;
         end
         default: w_state_nxt = S_RUN;
      endcase
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: scoreboard of expected decode-side outputs fed by an issue-stream model.
module tb_fetch_stage;
   localparam int          PC_W = 16;
   localparam logic [15:0] NOP  = 16'hC0F0;
   localparam logic [15:0] HLT  = 16'hC0FF;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   fetch_stage_if #(.PC_W(PC_W)) bus ();

   fetch_stage #(
      .PC_W(PC_W), .RESET_PC(16'h0000), .NOP_WORD(NOP), .HALT_WORD(HLT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   logic [15:0] mem [0:65535];
   always @(posedge clk) bus.imem_rdata <= mem[bus.imem_addr];

   typedef struct {
      logic [15:0] cmd;
      logic [15:0] bef;
      logic [15:0] two;
      logic [15:0] cpc;
      bit          cpc_chk;
      bit          hlt;
   } exp_t;

   exp_t sbq[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   // Reference: the stream of issued words; COMMAND and history are its last three entries.
   logic [15:0] hist[$];
   logic [15:0] m_next;
   logic [15:0] m_cpc;
   logic [15:0] m_halt_pc;
   int          m_bub;
   bit          m_cpc_ok;
   bit          m_halt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   task automatic model_reset();
      hist = '{NOP, NOP, NOP};
      m_next = 16'h0000; m_cpc = 16'h0000; m_cpc_ok = 1'b1;
      m_bub = 1; m_halt = 1'b0; m_halt_pc = 16'h0000;
   endtask

   task automatic issue(input logic [15:0] w);
      hist.push_back(w);
      if (hist.size() > 3) void'(hist.pop_front());
   endtask

   task automatic model_step(input bit st, input bit br, input logic [15:0] tgt);
      logic [15:0] w;
      if (m_halt) begin
         issue(NOP);
      end else if (br) begin
         issue(NOP); m_bub = 1; m_next = tgt; m_cpc_ok = 1'b0;
      end else if (st) begin
      end else if (m_bub > 0) begin
         issue(NOP); m_bub--; m_cpc_ok = 1'b0;
      end else begin
         w = mem[m_next];
         issue(w); m_cpc = m_next; m_cpc_ok = 1'b1;
         if (w == HLT) begin m_halt = 1'b1; m_halt_pc = m_next; end
         m_next = m_next + 16'd1;
      end
   endtask

   task automatic cycle(input bit st, input bit br, input logic [15:0] tgt);
      exp_t        e;
      logic [15:0] a;
      @(negedge clk);
      bus.stall = st; bus.branch_taken = br; bus.branch_target = tgt;
      #1;
      if (m_halt) begin
         a = m_halt_pc + 16'd2;
         chk("halt_pc_frozen", bus.imem_addr, a);
      end else if (st && !br) begin
         chk("stall_reread_addr", bus.imem_addr, m_next);
      end
      model_step(st, br, tgt);
      e.cmd = hist[2]; e.bef = hist[1]; e.two = hist[0];
      e.cpc = m_cpc; e.cpc_chk = m_cpc_ok; e.hlt = m_halt;
      sbq.push_back(e);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("rst_COMMAND", bus.COMMAND, NOP);
      chk("rst_Before", bus.BeforeCOMMAND, NOP);
      chk("rst_TwoBefore", bus.TwoBeforeCOMMAND, NOP);
      chk("rst_cmd_pc", bus.cmd_pc, 16'h0000);
      chk("rst_halted", bus.halted, 1'b0);
      model_reset();
      @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("COMMAND", bus.COMMAND, e.cmd);
            chk("BeforeCOMMAND", bus.BeforeCOMMAND, e.bef);
            chk("TwoBeforeCOMMAND", bus.TwoBeforeCOMMAND, e.two);
            if (e.cpc_chk) chk("cmd_pc", bus.cmd_pc, e.cpc);
            chk("halted", bus.halted, e.hlt);
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation exceeded its time bound");
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      logic [15:0] t;
      for (int i = 0; i < 65536; i++) begin
         do t = 16'($urandom); while (t == HLT);
         mem[i] = t;
      end
      mem[0] = 16'h4101; mem[1] = 16'h4202; mem[2] = 16'hC120; mem[3] = 16'hC230;
      bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = '0;
      model_reset();

      // Sequential run, then a 3-cycle stall while COMMAND holds 4202.
      do_reset();
      repeat (3) cycle(1'b0, 1'b0, 16'h0);
      repeat (3) cycle(1'b1, 1'b0, 16'h0);
      repeat (4) cycle(1'b0, 1'b0, 16'h0);

      // Branch to 0x20 while COMMAND is addr 1.
      do_reset();
      repeat (3) cycle(1'b0, 1'b0, 16'h0);
      cycle(1'b0, 1'b1, 16'h0020);
      repeat (4) cycle(1'b0, 1'b0, 16'h0);

      // Branch and stall together, stalls during the bubbles, back-to-back branches.
      cycle(1'b1, 1'b1, 16'h0040);
      cycle(1'b1, 1'b0, 16'h0);
      repeat (3) cycle(1'b0, 1'b0, 16'h0);
      cycle(1'b0, 1'b1, 16'h0010);
      cycle(1'b0, 1'b1, 16'h0030);
      repeat (4) cycle(1'b0, 1'b0, 16'h0);

      // PC wrap through the top of the address space.
      cycle(1'b0, 1'b1, 16'hFFFE);
      repeat (6) cycle(1'b0, 1'b0, 16'h0);

      for (int i = 0; i < 400; i++) begin
         t = 16'($urandom_range(4200, 16));
         cycle($urandom_range(3) == 0, $urandom_range(9) == 0, t);
      end

      // Reset asserted in the middle of a stall.
      cycle(1'b1, 1'b0, 16'h0);
      cycle(1'b1, 1'b0, 16'h0);
      do_reset();
      repeat (5) cycle(1'b0, 1'b0, 16'h0);

      // HALT at address 4, then stall/branch must be ignored while history drains.
      mem[4] = HLT;
      do_reset();
      repeat (6) cycle(1'b0, 1'b0, 16'h0);
      for (int i = 0; i < 8; i++) begin
         t = 16'($urandom);
         cycle($urandom_range(1) == 1, $urandom_range(1) == 1, t);
      end

      @(posedge clk);
      #3;
      chk("scoreboard_drained", sbq.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction fetch and history stage sitting directly upstream of the decode unit. It owns the program counter and drives a synchronous-read instruction memory. It presents the current instruction on COMMAND and the two previous issued instructions on BeforeCOMMAND and TwoBeforeCOMMAND, which the decoder uses for forwarding. It also handles branch redirect, pipeline stall, bubble insertion and HALT.

Parameters:
PC_W, 16, program counter / instruction address width
RESET_PC, 0, first fetch address after reset
NOP_WORD, 16'hC0F0, bubble encoding (arith class, op 1111: no write, ALU INON)
HALT_WORD, 16'hC0FF, halt encoding (decoder treats it as a NOP)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
imem_addr  out  PC_W  instruction memory read address
imem_rdata  in  16  instruction memory data, valid the cycle after imem_addr
stall  in  1  hold COMMAND, history and PC this cycle
branch_taken  in  1  redirect request from execute
branch_target  in  PC_W  redirect address
COMMAND  out  16  instruction presented to decode
BeforeCOMMAND  out  16  instruction issued one slot earlier
TwoBeforeCOMMAND  out  16  instruction issued two slots earlier
cmd_pc  out  PC_W  address of COMMAND
halted  out  1  HALT reached

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous active-low on rst_n. All registers clear immediately on rst_n=0.
- Reset values:
  - pc = RESET_PC, rd_pc = RESET_PC
  - fv = 0, where fv means imem_rdata holds a valid, non-squashed fetch
  - COMMAND, BeforeCOMMAND and TwoBeforeCOMMAND = NOP_WORD
  - cmd_pc = 0, halted = 0, state = RUN
- Internal registers:
  - pc: address being issued this cycle.
  - rd_pc: address whose data is on imem_rdata this cycle.
- Address mux (combinational): imem_addr = (stall && !branch_taken) ? rd_pc : pc. A stall re-reads the in-flight word so no instruction is lost.
- Normal cycle (RUN, no stall, no branch):
  - pc <= pc+1 (wraps modulo 2^PC_W); rd_pc <= pc; fv <= 1.
  - COMMAND <= fv ? imem_rdata : NOP_WORD; cmd_pc <= rd_pc.
  - BeforeCOMMAND <= COMMAND; TwoBeforeCOMMAND <= BeforeCOMMAND.
- Stall (RUN, no branch):
  - pc, COMMAND, BeforeCOMMAND, TwoBeforeCOMMAND, cmd_pc and fv all hold.
  - rd_pc holds, since it is re-issued.
- Branch (RUN, takes priority over stall):
  - pc <= branch_target; rd_pc <= branch_target; fv <= 0, squashing the in-flight word.
  - COMMAND <= NOP_WORD; the history shifts as in a normal cycle.
  - The next non-stalled cycle also loads NOP (fv=0). Branch penalty is 2 bubbles; the target instruction reaches COMMAND 2 non-stalled cycles after the branch.
- Latency: first real instruction (RESET_PC) appears on COMMAND at the 2nd rising edge after reset release.
- HALT:
  - When a non-stalled update loads HALT_WORD into COMMAND, state <= HALT and halted <= 1 on that same edge.
  - In HALT: pc frozen; every edge shifts NOP_WORD into COMMAND so the history drains; stall and branch_taken are ignored.
  - HALT exits only through reset.
- Simultaneous stall and branch: the branch wins.
- Branch while fv=0 (back-to-back branches): the last branch wins; no spurious instruction issues.
- Reset asserted mid-stall or mid-branch: all state returns to reset values immediately. Fetch restarts from RESET_PC with the same 2-cycle latency.
- No combinational path from imem_rdata to any output.

Test Plan:
- Sequential run: imem[0..3] = 16'h4101, 16'h4202, 16'hC120, 16'hC230, no stall. COMMAND shows 4101, 4202, C120, C230 on edges 2..5; cmd_pc = 0..3. At edge 5, BeforeCOMMAND = C120 and TwoBeforeCOMMAND = 4202.
- Stall: stall=1 for 3 cycles while COMMAND = 4202. COMMAND, history and cmd_pc hold for 3 cycles; imem_addr = rd_pc throughout. After release the next COMMAND is C120 (no drop, no duplicate).
- Branch: branch_taken=1, branch_target=16'h0020 while COMMAND = addr 1. The next 2 COMMANDs are C0F0; then COMMAND = imem[0x20] with cmd_pc = 0x0020. History shows addr1, C0F0, C0F0 in order.
- Branch plus stall in the same cycle: redirect happens and pc = target. Also: two consecutive branches (0x10 then 0x30) yield only imem[0x30] after the bubbles.
- HALT at addr 4: halted rises on the edge COMMAND becomes C0FF. pc stays 6; subsequent COMMANDs are C0F0; branch_taken=1 has no effect.
- Wrap and reset: PC_W=4, run from 14. cmd_pc goes 14, 15, 0, 1. Asserting rst_n=0 mid-stall clears all outputs immediately; after release COMMAND = imem[RESET_PC] at edge 2.
